cp0_regfile: RTL and testbench

- CP0 register file: the responder for the WB-stage exception/CP0 write-back interface.
- Accepts mtc0 writes, exception and eret reports from WB, and answers mfc0 reads.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC; generates the timer interrupt and the pending-interrupt request.
- Supplies the flush redirect target (exception vector or EPC) to the fetch stage.

---
 rtl/cp0_regfile_if.sv | 24 ++
 rtl/cp0_regfile.sv | 143 ++++++++++++++
 tb/tb_cp0_regfile.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_if.sv
// WB-stage exception / CP0 write-back interface. The master (WB stage) issues mtc0,
// exception and eret; the slave (CP0) returns mfc0 data, EPC, EXL and the flush target.
interface cp0_regfile_if;
  logic        c0_we;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;
  logic        c0_eret_flush;
  logic [38:0] c0_exception;  // {bd, ex, exccode[4:0], badvaddr[31:0]}
  logic [31:0] c0_pc;
  logic [31:0] c0_epc;
  logic        c0_status_exl;
  logic [31:0] flush_target;

  modport master (
    output c0_we, c0_addr, c0_wdata, c0_eret_flush, c0_exception, c0_pc,
    input  c0_rdata, c0_epc, c0_status_exl, flush_target
  );

  modport slave (
    input  c0_we, c0_addr, c0_wdata, c0_eret_flush, c0_exception, c0_pc,
    output c0_rdata, c0_epc, c0_status_exl, flush_target
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, the timer
// interrupt, the pending-interrupt request and the fetch redirect target.
module cp0_regfile #(
  parameter logic [31:0] EX_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV = 2
) (
  input  logic         clk,
  input  logic         resetn,
  cp0_regfile_if.slave bus,
  input  logic [5:0]   ext_int,
  output logic         int_pending
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef struct packed {
    logic        bd;
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  exception_t exc;
  assign exc = bus.c0_exception;

  logic [31:0] badvaddr, count, compare, epc;
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd, cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic        tick;

  logic wr_badvaddr_unused;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic count_inc, bad_addr_exc;

  assign wr_count   = bus.c0_we && (bus.c0_addr == ADDR_COUNT);
  assign wr_compare = bus.c0_we && (bus.c0_addr == ADDR_COMPARE);
  assign wr_status  = bus.c0_we && (bus.c0_addr == ADDR_STATUS);
  assign wr_cause   = bus.c0_we && (bus.c0_addr == ADDR_CAUSE);
  assign wr_epc     = bus.c0_we && (bus.c0_addr == ADDR_EPC);
  // BadVAddr is read-only to software; the decode is kept only for symmetry of the map.
  assign wr_badvaddr_unused = bus.c0_we && (bus.c0_addr == ADDR_BADVADDR);

  assign count_inc    = (COUNT_DIV == 1) ? 1'b1 : tick;
  assign bad_addr_exc = exc.ex && ((exc.exccode == EXC_ADEL) || (exc.exccode == EXC_ADES));

  // NOTE: every register here uses non-blocking assignment so all fields see
  // pre-edge values; within one block the later assignment wins, which is how
  // the exception overrides a simultaneous mtc0 on the fields it owns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick    <= 1'b0;
      count   <= '0;
      compare <= '0;
      cause_ti <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wr_count)       count <= bus.c0_wdata;
      else if (count_inc) count <= count + 32'd1;
      if (wr_compare) compare <= bus.c0_wdata;
      // Compare write clears TI and beats a same-cycle match.
      if (wr_compare)              cause_ti <= 1'b0;
      else if (count == compare)   cause_ti <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im  <= bus.c0_wdata[15:8];
        status_exl <= bus.c0_wdata[1];
        status_ie  <= bus.c0_wdata[0];
      end
      if (bus.c0_eret_flush) status_exl <= 1'b0;
      if (exc.ex)            status_exl <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_bd      <= 1'b0;
      cause_ip_hw   <= '0;
      cause_ip_sw   <= '0;
      cause_exccode <= '0;
      epc           <= '0;
      badvaddr      <= '0;
    end else begin
      cause_ip_hw <= {ext_int[5] | cause_ti, ext_int[4:0]};
      if (wr_cause) cause_ip_sw <= bus.c0_wdata[9:8];
      if (wr_epc)   epc <= bus.c0_wdata;
      if (exc.ex) begin
        cause_exccode <= exc.exccode;
        if (!status_exl) begin
          epc      <= exc.bd ? (bus.c0_pc - 32'd4) : bus.c0_pc;
          cause_bd <= exc.bd;
        end
      end
      if (bad_addr_exc) badvaddr <= exc.badvaddr;
    end
  end

  logic [31:0] status_val, cause_val;
  assign status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                       1'b0, cause_exccode, 2'b0};

  // NOTE: default assignment first so the unmapped-address path cannot infer a latch.
  always_comb begin
    bus.c0_rdata = '0;
    case (bus.c0_addr)
      ADDR_BADVADDR: bus.c0_rdata = badvaddr;
      ADDR_COUNT:    bus.c0_rdata = count;
      ADDR_COMPARE:  bus.c0_rdata = compare;
      ADDR_STATUS:   bus.c0_rdata = status_val;
      ADDR_CAUSE:    bus.c0_rdata = cause_val;
      ADDR_EPC:      bus.c0_rdata = epc;
      default:       bus.c0_rdata = '0;
    endcase
  end

  assign bus.c0_epc        = epc;
  assign bus.c0_status_exl = status_exl;
  assign bus.flush_target  = exc.ex ? EX_VECTOR : epc;

  assign int_pending = status_ie & ~status_exl &
                       (|({cause_ip_hw, cause_ip_sw} & status_im));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV=2, default EX_VECTOR).
module tb_cp0_regfile;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] ext_int = '0;
  logic       int_pending;

  int checks = 0;
  int errors = 0;

  cp0_regfile_if bus();

  cp0_regfile #(.EX_VECTOR(32'hBFC0_0380), .COUNT_DIV(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .ext_int     (ext_int),
    .int_pending (int_pending)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled around the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read(input logic [7:0] addr, output logic [31:0] data);
    bus.c0_addr = addr;
    #1;
    data = bus.c0_rdata;
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    bus.c0_we    = 1'b1;
    bus.c0_addr  = addr;
    bus.c0_wdata = data;
    cycle();
    bus.c0_we    = 1'b0;
  endtask

  task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    read(8'h60, d); expect32("reset_status", d, 32'h0040_0000);
    read(8'h68, d); expect32("reset_cause", d, 32'h0000_0000);
    read(8'h70, d); expect32("reset_epc", d, 32'h0000_0000);
    expect32("reset_int_pending", {31'b0, int_pending}, 32'd0);
    expect32("reset_flush_target", bus.flush_target, 32'h0000_0000);
    @(negedge clk);
    // Count==Compare==0 right after reset sets TI; move Compare out of the way.
    mtc0(8'h58, 32'hFFFF_0000);
    cycle();
  endtask

  task automatic test_write_mask();
    logic [31:0] d;
    mtc0(8'h60, 32'hFFFF_FFFF);
    read(8'h60, d); expect32("status_mask", d, 32'h0040_FF03);
    mtc0(8'h68, 32'hFFFF_FFFF);
    read(8'h68, d); expect32("cause_mask", d, 32'h0000_0300);
    mtc0(8'h00, 32'hDEAD_BEEF);
    read(8'h00, d); expect32("unmapped_read", d, 32'h0000_0000);
    mtc0(8'h60, 32'h0000_0000);
    mtc0(8'h68, 32'h0000_0000);
  endtask

  task automatic test_exception();
    logic [31:0] d;
    bus.c0_pc        = 32'h8000_1004;
    bus.c0_exception = {1'b1, 1'b1, 5'h04, 32'h1234_5671};
    #1;
    expect32("ex_flush_target", bus.flush_target, 32'hBFC0_0380);
    cycle();
    bus.c0_exception = '0;
    read(8'h70, d); expect32("ex_epc", d, 32'h8000_1000);
    read(8'h68, d); expect32("ex_cause", d, 32'h8000_0010);
    read(8'h40, d); expect32("ex_badvaddr", d, 32'h1234_5671);
    expect32("ex_exl", {31'b0, bus.c0_status_exl}, 32'd1);
    expect32("ex_c0_epc", bus.c0_epc, 32'h8000_1000);
  endtask

  task automatic test_nested_eret();
    logic [31:0] d;
    bus.c0_pc        = 32'h8000_2000;
    bus.c0_exception = {1'b0, 1'b1, 5'h0C, 32'h0000_0000};
    cycle();
    bus.c0_exception = '0;
    read(8'h70, d); expect32("nested_epc", d, 32'h8000_1000);
    read(8'h68, d); expect32("nested_exccode", {27'b0, d[6:2]}, 32'h0000_000C);
    read(8'h40, d); expect32("nested_badvaddr", d, 32'h1234_5671);
    bus.c0_eret_flush = 1'b1;
    cycle();
    bus.c0_eret_flush = 1'b0;
    #1;
    expect32("eret_exl", {31'b0, bus.c0_status_exl}, 32'd0);
    expect32("eret_flush_target", bus.flush_target, 32'h8000_1000);
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int waited;
    mtc0(8'h48, 32'd0);
    mtc0(8'h58, 32'd5);
    mtc0(8'h60, 32'h0000_8001);
    waited = 0;
    while (int_pending !== 1'b1 && waited < 40) begin
      cycle();
      waited++;
    end
    checks++;
    if (int_pending !== 1'b1) begin
      errors++;
      $display("FAIL timer_int_pending: got %b expected 1 within 40 cycles", int_pending);
    end
    read(8'h68, d); expect32("timer_ti", {31'b0, d[30]}, 32'd1);
    mtc0(8'h58, 32'd100);
    read(8'h68, d); expect32("timer_ti_clear", {31'b0, d[30]}, 32'd0);
    cycle();
    #1;
    expect32("timer_int_clear", {31'b0, int_pending}, 32'd0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    bus.c0_pc        = 32'h8000_3000;
    bus.c0_exception = {1'b0, 1'b1, 5'h08, 32'h0000_0000};
    mtc0(8'h60, 32'h0000_0000);
    bus.c0_exception = '0;
    read(8'h60, d); expect32("sim_status", d, 32'h0040_0002);
    read(8'h70, d); expect32("sim_epc", d, 32'h8000_3000);
    // eret together with an exception: the exception keeps EXL set.
    bus.c0_exception  = {1'b0, 1'b1, 5'h08, 32'h0000_0000};
    bus.c0_eret_flush = 1'b1;
    cycle();
    bus.c0_exception  = '0;
    bus.c0_eret_flush = 1'b0;
    #1;
    expect32("sim_ex_eret_exl", {31'b0, bus.c0_status_exl}, 32'd1);
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    mtc0(8'h48, 32'hFFFF_FFFF);
    read(8'h48, d); expect32("count_load", d, 32'hFFFF_FFFF);
    cycle();
    cycle();
    read(8'h48, d); expect32("count_wrap", d, 32'h0000_0000);
  endtask

  initial begin
    bus.c0_we         = 1'b0;
    bus.c0_addr       = 8'h00;
    bus.c0_wdata      = '0;
    bus.c0_eret_flush = 1'b0;
    bus.c0_exception  = '0;
    bus.c0_pc         = '0;
    test_reset();
    test_write_mask();
    test_exception();
    test_nested_eret();
    test_timer();
    test_simultaneous();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
